// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner and fetch buffer for the core front end.
// Issues word-aligned reads to instruction memory and collects in-order
// responses into a PC-tagged circular buffer that decode drains.
// Optional build macro IF_MISALIGN_CHECK_EN: a misaligned redirect raises a
// sticky fetch_fault and blocks issue until an aligned redirect or reset.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [PW-1:0]    fptr_q, fptr_d;   // oldest unfilled entry
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    ufill_q, ufill_d; // allocated but not yet filled
  logic [CW-1:0]    drop_q, drop_d;   // stale responses still to discard
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];

  logic fault_blk;
  logic issue, pop, rsp_drop, rsp_fill;

`ifdef IF_MISALIGN_CHECK_EN
  logic fault_q, fault_d;

  // Sticky fault: every redirect re-evaluates it from the target alignment.
  always_comb begin
    fault_d = fault_q;
    if (redirect_valid) fault_d = |redirect_pc[1:0];
  end

  // Fault register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end

  assign fault_blk   = fault_q;
  assign fetch_fault = fault_q;
`else
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^redirect_pc[1:0];
  assign fault_blk     = 1'b0;
  assign fetch_fault   = 1'b0;
`endif

  assign imem_req_valid = rst_n && !redirect_valid && !fault_blk &&
                          (({1'b0, count_q} + {1'b0, drop_q}) < DEPTH_L);
  assign imem_req_addr  = fetch_pc_q;
  assign inst_valid     = (count_q != '0) && filled_q[head_q];
  assign inst_pc        = pc_q[head_q];
  assign inst_data      = data_q[head_q];

  assign issue    = imem_req_valid && imem_req_ready;
  assign pop      = inst_valid && inst_ready && !redirect_valid;
  assign rsp_drop = imem_rsp_valid && !redirect_valid && (drop_q != '0);
  assign rsp_fill = imem_rsp_valid && !redirect_valid && (drop_q == '0) && (ufill_q != '0);

  // Next-state for PC, pointers, occupancy and drop accounting.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fptr_d     = fptr_q;
    count_d    = count_q;
    ufill_d    = ufill_q;
    drop_d     = drop_q;
    filled_d   = filled_q;
    if (redirect_valid) begin
      // Every outstanding request becomes stale; a response landing this
      // cycle retires one of them immediately.
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      head_d     = '0;
      tail_d     = '0;
      fptr_d     = '0;
      count_d    = '0;
      ufill_d    = '0;
      drop_d     = drop_q + ufill_q - CW'(imem_rsp_valid);
      filled_d   = '0;
    end else begin
      if (issue) begin
        fetch_pc_d       = fetch_pc_q + 32'd4;
        tail_d           = tail_q + 1'b1;
        filled_d[tail_q] = 1'b0;
      end
      if (pop) head_d = head_q + 1'b1;
      if (rsp_fill) begin
        fptr_d           = fptr_q + 1'b1;
        filled_d[fptr_q] = 1'b1;
      end
      count_d = count_q + CW'(issue) - CW'(pop);
      ufill_d = ufill_q + CW'(issue) - CW'(rsp_fill);
      drop_d  = drop_q - CW'(rsp_drop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      fptr_q     <= '0;
      count_q    <= '0;
      ufill_q    <= '0;
      drop_q     <= '0;
      filled_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fptr_q     <= fptr_d;
      count_q    <= count_d;
      ufill_q    <= ufill_d;
      drop_q     <= drop_d;
      filled_q   <= filled_d;
    end
  end

  // Buffer payload: PC captured at issue, data captured at fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (issue)    pc_q[tail_q]   <= fetch_pc_q;
      if (rsp_fill) data_q[fptr_q] <= imem_rsp_data;
    end
  end
endmodule
